// File: rtl/sd_data_rx_deser_pkg.sv
// rtl/sd_data_rx_deser_pkg.sv - shared SD RX deserializer defines
package sd_data_rx_deser_pkg;

   localparam int SD_BUS_W_DEF = 4;
   localparam int BLK_NIB_DEF  = 1024;

   // CRC16-CCITT generator x^16 + x^12 + x^5 + 1 (x^16 term implicit)
   localparam logic [15:0] CRC16_POLY = 16'h1021;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_WAIT_START = 3'd1;
   localparam logic [2:0] ST_DATA       = 3'd2;
   localparam logic [2:0] ST_CRC        = 3'd3;
   localparam logic [2:0] ST_END        = 3'd4;
   localparam logic [2:0] ST_DONE       = 3'd5;

   // One serial CRC step, MSB first, zero-initialised register
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
      return {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/sd_data_rx_deser_if.sv
// rtl/sd_data_rx_deser_if.sv - control and FIFO-side signals of the RX deserializer
interface sd_data_rx_deser_if #(parameter int W = sd_data_rx_deser_pkg::SD_BUS_W_DEF);

   logic         en;
   logic [7:0]   blk_num;
   logic [W-1:0] dat_i;
   logic         full_i;
   logic         wr_o;
   logic [W-1:0] dat_o;
   logic         busy_o;
   logic         done_o;
   logic         crc_err_o;
   logic         ovr_o;
   logic         tout_o;

   modport master (
      output en, blk_num, dat_i, full_i,
      input  wr_o, dat_o, busy_o, done_o, crc_err_o, ovr_o, tout_o
   );

   modport slave (
      input  en, blk_num, dat_i, full_i,
      output wr_o, dat_o, busy_o, done_o, crc_err_o, ovr_o, tout_o
   );

endinterface

// File: rtl/sd_data_rx_deser_crc.sv
// rtl/sd_data_rx_deser_crc.sv - serial CRC16 for one SD data line
module sd_crc_16
   import sd_data_rx_deser_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        clr,
   input  logic        bit_in,
   output logic [15:0] crc
);

   // Clear wins over shift so a new block always starts from zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         crc <= 16'h0000;
      else if (clr)
         crc <= 16'h0000;
      else if (en)
         crc <= crc16_step(crc, bit_in);
   end

endmodule

// File: rtl/sd_data_rx_deser.sv
// rtl/sd_data_rx_deser.sv - SD wide-bus block receiver: start detect, nibble deserialize, CRC check
module sd_data_rx_deser
   import sd_data_rx_deser_pkg::*;
#(
   parameter int          SD_BUS_W = SD_BUS_W_DEF,
   parameter int          BLK_NIB  = BLK_NIB_DEF,
   parameter logic [15:0] TOUT     = 16'hFFFF
)
(
   input logic             sd_clk,
   input logic             rst,
   sd_data_rx_deser_if.slave bus
);

   localparam logic [9:0] NIB_LAST = 10'(BLK_NIB - 1);

   logic [2:0]  state;
   logic [9:0]  nib_cnt;
   logic [3:0]  bit_cnt;
   logic [15:0] tcnt;
   logic [7:0]  blk_cnt;
   logic [15:0] crc_q [SD_BUS_W];
   logic        crc_en;
   logic        crc_clr;
   logic        crc_bad;

   // CRCs run only on data nibbles; clearing in IDLE and END means every
   // WAIT_START entry sees zeroed registers
   assign crc_en  = (state == ST_DATA);
   assign crc_clr = (state == ST_IDLE) || (state == ST_END);

   assign bus.busy_o = (state != ST_IDLE) && (state != ST_DONE);

   for (genvar k = 0; k < SD_BUS_W; k++) begin : g_crc
      sd_crc_16 u_crc (
         .clk    (sd_clk),
         .rst    (rst),
         .en     (crc_en),
         .clr    (crc_clr),
         .bit_in (bus.dat_i[k]),
         .crc    (crc_q[k])
      );
   end

   // Compare each line's received CRC bit, MSB first, against its computed CRC
   always_comb begin
      crc_bad = 1'b0;
      for (int k = 0; k < SD_BUS_W; k++) begin
         if (bus.dat_i[k] != crc_q[k][4'd15 - bit_cnt])
            crc_bad = 1'b1;
      end
   end

   // Block FSM, counters, FIFO write path and sticky status flags
   always_ff @(posedge sd_clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_IDLE;
         nib_cnt       <= '0;
         bit_cnt       <= '0;
         tcnt          <= '0;
         blk_cnt       <= '0;
         bus.wr_o      <= 1'b0;
         bus.dat_o     <= '0;
         bus.done_o    <= 1'b0;
         bus.crc_err_o <= 1'b0;
         bus.ovr_o     <= 1'b0;
         bus.tout_o    <= 1'b0;
      end else begin
         bus.done_o <= 1'b0;
         // The nibble sampled this cycle is written next cycle even on abort
         bus.wr_o   <= (state == ST_DATA);
         if (state == ST_DATA)
            bus.dat_o <= bus.dat_i;
         // The FIFO drops a write while full; flag it but keep receiving
         if (bus.wr_o && bus.full_i)
            bus.ovr_o <= 1'b1;

         if (!bus.en) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  state         <= ST_WAIT_START;
                  bus.crc_err_o <= 1'b0;
                  bus.ovr_o     <= 1'b0;
                  bus.tout_o    <= 1'b0;
                  blk_cnt       <= (bus.blk_num == 8'd0) ? 8'd1 : bus.blk_num;
                  tcnt          <= '0;
               end
               ST_WAIT_START: begin
                  if (bus.dat_i == '0) begin
                     state   <= ST_DATA;
                     nib_cnt <= '0;
                  end else if (tcnt >= TOUT - 16'd1) begin
                     bus.tout_o <= 1'b1;
                     state      <= ST_DONE;
                  end else begin
                     tcnt <= tcnt + 16'd1;
                  end
               end
               ST_DATA: begin
                  if (nib_cnt == NIB_LAST) begin
                     state   <= ST_CRC;
                     bit_cnt <= '0;
                  end else begin
                     nib_cnt <= nib_cnt + 10'd1;
                  end
               end
               ST_CRC: begin
                  if (crc_bad)
                     bus.crc_err_o <= 1'b1;
                  if (bit_cnt == 4'd15)
                     state <= ST_END;
                  else
                     bit_cnt <= bit_cnt + 4'd1;
               end
               ST_END: begin
                  // A missing end bit is reported as a CRC/framing error
                  if (bus.dat_i != '1)
                     bus.crc_err_o <= 1'b1;
                  blk_cnt <= blk_cnt - 8'd1;
                  if (blk_cnt <= 8'd1) begin
                     state      <= ST_DONE;
                     bus.done_o <= 1'b1;
                  end else begin
                     state <= ST_WAIT_START;
                     tcnt  <= '0;
                  end
               end
               ST_DONE: begin
                  state <= ST_DONE;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
